// File: rtl/eth_types_pkg.sv
// Shared Ethernet/IPv4/UDP types and constants for the receive and transmit paths.
package eth_types_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ETH_HDR,
    S_IP_HDR,
    S_UDP_HDR,
    S_PAYLOAD,
    S_DRAIN
  } rx_demux_state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } frame_header;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] ident;
    logic [2:0]  flags;
    logic [12:0] frag_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ip_header;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_header;

  // Two end-around-carry folds of a 32-bit ones-complement accumulator.
  function automatic logic [15:0] csum_fold(input logic [31:0] acc);
    logic [31:0] t;
    t = {16'd0, acc[31:16]} + {16'd0, acc[15:0]};
    t = {16'd0, t[31:16]} + {16'd0, t[15:0]};
    return t[15:0];
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial ones-complement accumulator. The folded sum already includes the
// byte presented this cycle, so a caller can judge a header on its last byte.
module ip_csum_acc
  import eth_types_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        byte_en,
  input  logic        odd,
  input  logic [7:0]  byte_in,
  output logic [15:0] sum
);

  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [31:0] addend;

  // Even bytes are the MSB of a 16-bit word, odd bytes the LSB.
  always_comb begin
    addend   = odd ? {24'd0, byte_in} : {16'd0, byte_in, 8'd0};
    acc_next = (clear ? 32'd0 : acc) + (byte_en ? addend : 32'd0);
  end

  // Accumulator register; clear restarts the sum.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= 32'd0;
    end else if (clear || byte_en) begin
      acc <= acc_next;
    end
  end

  assign sum = csum_fold(acc_next);

endmodule

// File: rtl/udp_rx_demux.sv
// Ethernet II / IPv4 / UDP receive parser that steers UDP payload to one of
// NUM_PORTS channels by destination port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for SFD (0xD5)
// ETH_HDR   | 14 bytes: dest MAC, src MAC, ethertype
// IP_HDR    | IHL*4 bytes, checksum summed, addresses/protocol/frag checked
// UDP_HDR   | 8 bytes: dest port and length, channel lookup
// PAYLOAD   | udp_len-8 bytes forwarded to the matched channel
// DRAIN     | padding/FCS/rejected frame ignored until frame_end
module udp_rx_demux
  import eth_types_pkg::*;
#(
  parameter logic [47:0]           FPGA_MAC     = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0]           FPGA_IP      = 32'hC0_00_02_92,
  parameter int                    NUM_PORTS    = 2,
  parameter logic [NUM_PORTS*16-1:0] PORT_LIST  = {16'd5006, 16'd5005},
  parameter bit                    ACCEPT_BCAST = 1'b1,
  parameter int                    CNT_W        = 16,
  localparam int                   CHAN_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        received_byte,
  input  logic              byte_valid,
  input  logic              frame_end,
  output logic [7:0]        data,
  output logic              data_valid,
  output logic              data_last,
  output logic [CHAN_W-1:0] data_chan,
  output logic              data_abort,
  output logic [CNT_W-1:0]  drop_count
);

  rx_demux_state_t state, state_n;
  logic [15:0]       byte_cnt, cnt_n;
  logic [15:0]       remaining, rem_n;
  logic [CHAN_W-1:0] chan_sel, chan_n;

  logic [47:0] dst_mac;
  logic [7:0]  eth_type_hi;
  logic [5:0]  hdr_len;
  logic [15:0] total_len;
  logic        frag_bad;
  logic [7:0]  ip_proto;
  logic [31:0] ip_dst;
  logic [15:0] dst_port;
  logic [15:0] udp_len;
  logic [15:0] csum_sum;

  logic              eth_ok;
  logic              ip_ok;
  logic              ip_last;
  logic              udp_too_long;
  logic              port_hit;
  logic [CHAN_W-1:0] port_idx;
  logic [31:0]       ip_dst_eff;
  logic              emit;
  logic              last_beat;
  logic              abort;
  logic              drop;

  ip_csum_acc u_csum (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state == S_IDLE),
    .byte_en (byte_valid && (state == S_IP_HDR)),
    .odd     (byte_cnt[0]),
    .byte_in (received_byte),
    .sum     (csum_sum)
  );

  // Header acceptance terms; the final header byte is used straight from the input.
  always_comb begin
    ip_dst_eff   = (byte_cnt == 16'd19) ? {ip_dst[23:0], received_byte} : ip_dst;
    eth_ok       = ((dst_mac == FPGA_MAC) || (ACCEPT_BCAST && (dst_mac == MAC_BCAST))) &&
                   ({eth_type_hi, received_byte} == ETHERTYPE_IPV4);
    ip_last      = (byte_cnt != 16'd0) && (byte_cnt == ({10'd0, hdr_len} - 16'd1));
    ip_ok        = (csum_sum == 16'hFFFF) && (ip_proto == IP_PROTO_UDP) &&
                   (ip_dst_eff == FPGA_IP) && !frag_bad;
    udp_too_long = ({1'b0, udp_len} + {11'd0, hdr_len}) > {1'b0, total_len};
  end

  // Parallel port lookup; scanning downwards leaves the lowest matching index.
  always_comb begin
    port_hit = 1'b0;
    port_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (dst_port == PORT_LIST[16*i +: 16]) begin
        port_hit = 1'b1;
        port_idx = CHAN_W'(i);
      end
    end
  end

  // Next-state logic: the current byte is handled first, then frame_end forces IDLE.
  always_comb begin
    state_n   = state;
    cnt_n     = byte_cnt;
    rem_n     = remaining;
    chan_n    = chan_sel;
    emit      = 1'b0;
    last_beat = 1'b0;
    abort     = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (byte_valid && (received_byte == SFD_BYTE)) begin
          state_n = S_ETH_HDR;
          cnt_n   = 16'd0;
        end
      end
      S_ETH_HDR: begin
        if (byte_valid) begin
          cnt_n = byte_cnt + 16'd1;
          if (byte_cnt == 16'd13) begin
            cnt_n = 16'd0;
            if (eth_ok) begin
              state_n = S_IP_HDR;
            end else begin
              state_n = S_DRAIN;
              drop    = 1'b1;
            end
          end
        end
      end
      S_IP_HDR: begin
        if (byte_valid) begin
          cnt_n = byte_cnt + 16'd1;
          if ((byte_cnt == 16'd0) &&
              ((received_byte[7:4] != 4'd4) || (received_byte[3:0] < 4'd5))) begin
            state_n = S_DRAIN;
            drop    = 1'b1;
          end else if (ip_last) begin
            cnt_n = 16'd0;
            if (ip_ok) begin
              state_n = S_UDP_HDR;
            end else begin
              state_n = S_DRAIN;
              drop    = 1'b1;
            end
          end
        end
      end
      S_UDP_HDR: begin
        if (byte_valid) begin
          cnt_n = byte_cnt + 16'd1;
          if (byte_cnt == 16'd7) begin
            cnt_n = 16'd0;
            if (!port_hit || (udp_len < UDP_HDR_LEN) || udp_too_long) begin
              state_n = S_DRAIN;
              drop    = 1'b1;
            end else if (udp_len == UDP_HDR_LEN) begin
              state_n = S_DRAIN;
            end else begin
              state_n = S_PAYLOAD;
              rem_n   = udp_len - UDP_HDR_LEN;
              chan_n  = port_idx;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (byte_valid) begin
          emit  = 1'b1;
          rem_n = remaining - 16'd1;
          if (remaining == 16'd1) begin
            last_beat = 1'b1;
            state_n   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_n = S_DRAIN;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (frame_end) begin
      if ((state_n == S_ETH_HDR) || (state_n == S_IP_HDR) || (state_n == S_UDP_HDR)) begin
        drop = 1'b1;
      end
      if (state_n == S_PAYLOAD) begin
        abort = 1'b1;
      end
      state_n = S_IDLE;
    end
  end

  // State, byte counter, remaining-payload down-counter and selected channel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      byte_cnt  <= 16'd0;
      remaining <= 16'd0;
      chan_sel  <= '0;
    end else begin
      state     <= state_n;
      byte_cnt  <= cnt_n;
      remaining <= rem_n;
      chan_sel  <= chan_n;
    end
  end

  // Capture the header fields needed for filtering; option bytes only feed the checksum.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dst_mac     <= 48'd0;
      eth_type_hi <= 8'd0;
      hdr_len     <= 6'd0;
      total_len   <= 16'd0;
      frag_bad    <= 1'b0;
      ip_proto    <= 8'd0;
      ip_dst      <= 32'd0;
      dst_port    <= 16'd0;
      udp_len     <= 16'd0;
    end else if (byte_valid) begin
      if (state == S_ETH_HDR) begin
        if (byte_cnt < 16'd6)   dst_mac     <= {dst_mac[39:0], received_byte};
        if (byte_cnt == 16'd12) eth_type_hi <= received_byte;
      end
      if (state == S_IP_HDR) begin
        if (byte_cnt == 16'd0) hdr_len          <= {received_byte[3:0], 2'b00};
        if (byte_cnt == 16'd2) total_len[15:8]  <= received_byte;
        if (byte_cnt == 16'd3) total_len[7:0]   <= received_byte;
        if (byte_cnt == 16'd6) frag_bad         <= received_byte[5] | (|received_byte[4:0]);
        if (byte_cnt == 16'd7) frag_bad         <= frag_bad | (|received_byte);
        if (byte_cnt == 16'd9) ip_proto         <= received_byte;
        if ((byte_cnt >= 16'd16) && (byte_cnt <= 16'd19)) ip_dst <= {ip_dst[23:0], received_byte};
      end
      if (state == S_UDP_HDR) begin
        if (byte_cnt == 16'd2) dst_port[15:8] <= received_byte;
        if (byte_cnt == 16'd3) dst_port[7:0]  <= received_byte;
        if (byte_cnt == 16'd4) udp_len[15:8]  <= received_byte;
        if (byte_cnt == 16'd5) udp_len[7:0]   <= received_byte;
      end
    end
  end

  // Registered payload outputs; channel only updates on emitted bytes so it holds per frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data       <= 8'd0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      data_chan  <= '0;
      data_abort <= 1'b0;
    end else begin
      data_valid <= emit;
      data_last  <= last_beat;
      data_abort <= abort;
      if (emit) begin
        data      <= received_byte;
        data_chan <= chan_sel;
      end
    end
  end

  // Saturating count of frames rejected after SFD.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_udp_rx_demux.sv
// Frame-level bench: three instances (default, no broadcast, 2-bit drop counter)
// share one byte stream; payload beats of the default instance are scoreboarded.
module tb_udp_rx_demux;

  localparam logic [31:0] DUT_IP  = 32'hC000_0292;
  localparam logic [47:0] DUT_MAC = 48'h001A_2B3C_4D5E;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] received_byte = 8'h00;
  logic       byte_valid = 1'b0;
  logic       frame_end = 1'b0;

  logic [7:0]  data, nb_data, sat_data;
  logic        data_valid, nb_valid, sat_valid;
  logic        data_last, nb_last, sat_last;
  logic [0:0]  data_chan, nb_chan, sat_chan;
  logic        data_abort, nb_abort, sat_abort;
  logic [15:0] drop_count, nb_drop;
  logic [1:0]  sat_drop;

  udp_rx_demux dut (
    .clk(clk), .resetn(resetn), .received_byte(received_byte), .byte_valid(byte_valid),
    .frame_end(frame_end), .data(data), .data_valid(data_valid), .data_last(data_last),
    .data_chan(data_chan), .data_abort(data_abort), .drop_count(drop_count)
  );

  udp_rx_demux #(.ACCEPT_BCAST(1'b0)) dut_nb (
    .clk(clk), .resetn(resetn), .received_byte(received_byte), .byte_valid(byte_valid),
    .frame_end(frame_end), .data(nb_data), .data_valid(nb_valid), .data_last(nb_last),
    .data_chan(nb_chan), .data_abort(nb_abort), .drop_count(nb_drop)
  );

  udp_rx_demux #(.CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .received_byte(received_byte), .byte_valid(byte_valid),
    .frame_end(frame_end), .data(sat_data), .data_valid(sat_valid), .data_last(sat_last),
    .data_chan(sat_chan), .data_abort(sat_abort), .drop_count(sat_drop)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0] sb[$];
  int aborts = 0, exp_aborts = 0;
  int nb_beats = 0, exp_nb_beats = 0;
  int exp_drop = 0, exp_nb_drop = 0, exp_sat_drop = 0;

  // frame description used by send_frame
  logic [47:0] f_mac;
  int f_ihl, f_dport, f_plen, f_pad, f_cut, f_chan, f_tail;
  bit f_bad, f_same, f_exp, f_nb_ok, f_pre, f_noend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every beat of the default instance.
  always @(negedge clk) begin
    if (data_valid) begin
      if (sb.size() == 0) begin
        check_eq("beat_queued", 32'(sb.size()), 32'd1);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check_eq("beat", {22'd0, data_chan, data_last, data}, {22'd0, e});
      end
    end
    if (data_abort) aborts++;
    if (nb_valid) nb_beats++;
  end

  task automatic set_defaults();
    f_mac = DUT_MAC; f_ihl = 5; f_dport = 5005; f_plen = 18; f_pad = 0; f_cut = -1;
    f_chan = 0; f_tail = 3; f_bad = 0; f_same = 0; f_exp = 1; f_nb_ok = 1; f_pre = 1;
    f_noend = 0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit fe);
    received_byte = b; byte_valid = 1'b1; frame_end = fe;
    @(negedge clk);
    byte_valid = 1'b0; frame_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame();
    logic [7:0] ip[$];
    logic [7:0] f[$];
    logic [31:0] s;
    logic [15:0] ck;
    int hl, ulen, tot, nsend, beats;
    hl = f_ihl * 4; ulen = f_plen + 8; tot = hl + ulen;
    ip.push_back(8'h40 | 8'(f_ihl)); ip.push_back(8'h00);
    ip.push_back(tot[15:8]); ip.push_back(tot[7:0]);
    ip.push_back(8'h12); ip.push_back(8'h34); ip.push_back(8'h40); ip.push_back(8'h00);
    ip.push_back(8'd64); ip.push_back(8'd17); ip.push_back(8'h00); ip.push_back(8'h00);
    ip.push_back(8'hC0); ip.push_back(8'h00); ip.push_back(8'h02); ip.push_back(8'h01);
    for (int i = 3; i >= 0; i--) ip.push_back(DUT_IP[8*i +: 8]);
    for (int i = 0; i < (f_ihl - 5) * 4; i++) ip.push_back(8'h01);
    s = 32'd0;
    for (int i = 0; i < hl; i += 2) s = s + {16'd0, ip[i], ip[i+1]};
    s = {16'd0, s[31:16]} + {16'd0, s[15:0]};
    s = {16'd0, s[31:16]} + {16'd0, s[15:0]};
    ck = ~s[15:0];
    if (f_bad) ck[3] = ~ck[3];
    ip[10] = ck[15:8]; ip[11] = ck[7:0];
    for (int i = 5; i >= 0; i--) f.push_back(f_mac[8*i +: 8]);
    f.push_back(8'h02); for (int i = 0; i < 4; i++) f.push_back(8'h00); f.push_back(8'h01);
    f.push_back(8'h08); f.push_back(8'h00);
    foreach (ip[i]) f.push_back(ip[i]);
    f.push_back(8'h03); f.push_back(8'hE8);
    f.push_back(f_dport[15:8]); f.push_back(f_dport[7:0]);
    f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 0; i < f_plen; i++) f.push_back(8'(i));
    while (f.size() < f_pad) f.push_back(8'h00);
    nsend = (f_cut >= 0) ? (14 + hl + 8 + f_cut) : f.size();
    beats = (f_cut >= 0) ? f_cut : f_plen;
    if (f_exp) begin
      for (int i = 0; i < beats; i++) sb.push_back({f_chan[0], (i == f_plen - 1), 8'(i)});
      if (f_nb_ok) exp_nb_beats += beats;
    end
    if (f_pre) for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int k = 0; k < nsend; k++) drive_byte(f[k], f_same && (k == nsend - 1));
    if (!f_same && !f_noend) begin
      if (f_cut < 0) begin
        drive_byte(8'hD5, 1'b0); drive_byte(8'h3C, 1'b0);
        drive_byte(8'hA5, 1'b0); drive_byte(8'h0F, 1'b0);
      end
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
    end
    repeat (f_tail) @(negedge clk);
  endtask

  task automatic after_frame(input string tag);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check_eq({tag, "_drop"}, {16'd0, drop_count}, 32'(exp_drop));
    check_eq({tag, "_nb_drop"}, {16'd0, nb_drop}, 32'(exp_nb_drop));
    check_eq({tag, "_sat_drop"}, {30'd0, sat_drop}, 32'(exp_sat_drop));
    check_eq({tag, "_aborts"}, 32'(aborts), 32'(exp_aborts));
    check_eq({tag, "_nb_beats"}, 32'(nb_beats), 32'(exp_nb_beats));
  endtask

  task automatic drop_all();
    exp_drop++; exp_nb_drop++;
    exp_sat_drop = (exp_sat_drop < 3) ? exp_sat_drop + 1 : 3;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_data", {24'd0, data}, 32'd0);
    check_eq("rst_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rst_last", {31'd0, data_last}, 32'd0);
    check_eq("rst_chan", {31'd0, data_chan}, 32'd0);
    check_eq("rst_abort", {31'd0, data_abort}, 32'd0);
    check_eq("rst_drop", {16'd0, drop_count}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    set_defaults(); send_frame(); after_frame("ucast5005");

    set_defaults(); f_mac = BCAST; f_dport = 5006; f_chan = 1; f_nb_ok = 0;
    send_frame(); exp_nb_drop++; after_frame("bcast5006");

    set_defaults(); f_ihl = 6; f_plen = 10; send_frame(); after_frame("ihl6");

    set_defaults(); f_ihl = 6; f_plen = 10; f_bad = 1; f_exp = 0;
    send_frame(); drop_all(); after_frame("ihl6_badcsum");

    set_defaults(); f_mac = 48'h001A_2B3C_4D5F; f_exp = 0;
    send_frame(); drop_all(); after_frame("wrong_mac");

    set_defaults(); f_plen = 4; f_pad = 60; send_frame(); after_frame("len12_pad");

    set_defaults(); f_plen = 0; send_frame(); after_frame("len8");

    set_defaults(); f_cut = 5; f_tail = 0; exp_aborts++; send_frame();
    set_defaults(); f_pre = 0; f_dport = 5006; f_chan = 1; f_plen = 3;
    send_frame(); after_frame("trunc_then_b2b");

    set_defaults(); f_plen = 6; f_cut = 6; f_same = 1; send_frame(); after_frame("end_with_last");

    for (int n = 0; n < 5; n++) begin
      set_defaults(); f_dport = 1234; f_exp = 0;
      send_frame(); drop_all(); after_frame("port1234");
    end

    set_defaults(); f_cut = 8; f_noend = 1; f_tail = 0; send_frame();
    resetn = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", {31'd0, data_valid}, 32'd0);
    check_eq("midrst_abort", {31'd0, data_abort}, 32'd0);
    check_eq("midrst_data", {24'd0, data}, 32'd0);
    exp_drop = 0; exp_nb_drop = 0; exp_sat_drop = 0;
    resetn = 1'b1;
    @(negedge clk);
    after_frame("midrst");

    set_defaults(); f_plen = 2; send_frame(); after_frame("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_rx_demux.md
# udp_rx_demux

Parametrised successor to the single-port receive parser. It consumes the post-PHY byte stream (preamble, SFD, frame) on the 50 MHz RMII clock and parses Ethernet II, IPv4 and UDP headers. It filters on MAC, IP, protocol and header checksum, then steers the UDP payload to one of `NUM_PORTS` logical channels selected by destination port. Additional behaviour:
- variable IHL (IP options)
- optional broadcast acceptance
- truncation abort
- drop counter

## Interface
Parameters:
- `FPGA_MAC`, 48'h00_1A_2B_3C_4D_5E: unicast MAC accepted.
- `FPGA_IP`, 32'hC0_00_02_92: destination IP accepted.
- `NUM_PORTS`, 2: number of UDP channels, 1..8.
- `PORT_LIST`, {16'd5006, 16'd5005}: packed `NUM_PORTS*16`; entry i is bits [16i+15:16i].
- `ACCEPT_BCAST`, 1: also accept dest MAC FF:FF:FF:FF:FF:FF.
- `CNT_W`, 16: drop counter width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: 50 MHz LAN8720 clock.
- `resetn` input 1: asynchronous active-low reset.
- `received_byte` input 8: byte from the PHY interface.
- `byte_valid` input 1: qualifies `received_byte` for one cycle.
- `frame_end` input 1: one-cycle pulse at the end of the carrier (CRS_DV fall).
- `data` output 8: payload byte.
- `data_valid` output 1: `data` is valid this cycle.
- `data_last` output 1: asserted with the final payload byte.
- `data_chan` output `$clog2(NUM_PORTS)` (min 1): index of the matched `PORT_LIST` entry.
- `data_abort` output 1: one-cycle pulse; payload in progress was truncated.
- `drop_count` output `CNT_W`: frames rejected after SFD; saturating.

## Operation
- States: IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DRAIN.
- **IDLE:** wait for a valid 0xD5, then go to ETH_HDR with the byte counter at 0.
- **ETH_HDR (14 bytes):** capture dest MAC, src MAC and ethertype. On byte 13:
  - accept → IP_HDR when dest == `FPGA_MAC` (or broadcast with `ACCEPT_BCAST`=1) and ethertype == 16'h0800;
  - otherwise → DRAIN, drop.
- **IP_HDR:** byte 0 gives version and IHL.
  - Drop if version != 4 or IHL < 5.
  - Header length is IHL*4 bytes; option bytes are summed but not stored.
  - Each 16-bit word (MSB on the even byte) feeds a 32-bit accumulator, with the checksum field included.
  - At the last header byte, fold twice (`acc[31:16]+acc[15:0]`). Pass requires fold == 16'hFFFF, protocol == 8'd17, dest IP == `FPGA_IP`, and flags MF == 0 and frag_offset == 0.
  - Pass → UDP_HDR; otherwise → DRAIN, drop.
- **UDP_HDR (8 bytes):** capture dest port and `udp_len`. On byte 7, compare the dest port against all `PORT_LIST` entries in parallel; the lowest matching index wins.
  - No match, or `udp_len` < 8, or `udp_len` > total_len − IHL*4 → DRAIN, drop.
  - `udp_len` == 8 → DRAIN with no output and no drop.
  - Otherwise → PAYLOAD with remaining = `udp_len` − 8.
- **UDP checksum:** not checked.
- **PAYLOAD:** each valid byte is emitted on `data`. The byte where remaining == 1 asserts `data_last`, then → DRAIN.
- **DRAIN:** ignore padding and FCS until `frame_end`.
- **`frame_end` handling:** `frame_end` in any non-IDLE state → IDLE.
  - In PAYLOAD before the last byte: pulse `data_abort`, do not assert `data_last`, and do not count a drop.
  - In ETH_HDR, IP_HDR or UDP_HDR: count a drop.
- **`drop_count`:** increments once per rejected frame and saturates at all-ones.

## Timing
- Reset values: `data`=0, `data_valid`=0, `data_last`=0, `data_chan`=0, `data_abort`=0, `drop_count`=0, state=IDLE.
- Latency: `data`, `data_valid`, `data_last` and `data_chan` are registered, one cycle after the qualifying `byte_valid`.
- `data_valid` is high only on cycles following a PAYLOAD byte_valid.
- `data_chan` stays stable from the first payload byte through `data_last`.
- `byte_valid` and `frame_end` in the same cycle: the byte is processed first, then the state goes to IDLE. If that byte is the last payload byte, output `data_last` and no abort.
- Back-to-back frames: IDLE accepts an SFD on the cycle after `frame_end`.
- Reset asserted mid-frame: all outputs clear immediately; no abort pulse is generated.
- Counter widths: the byte counter is 16 bits; the remaining-byte counter is 16 bits.

## Structure
- `eth_types_pkg` gains:
  - the `rx_demux_state_t` enum;
  - `ETHERTYPE_IPV4`=16'h0800 and `IP_PROTO_UDP`=8'd17;
  - `MAC_BCAST`=48'hFFFF_FFFF_FFFF;
  - the existing `frame_header`, `ip_header` and `udp_header` structs.
- Sub-module `ip_csum_acc`: byte-in ones-complement accumulator with `clear`, `byte_en`, `odd` inputs and a folded `sum[15:0]` output. It is reused by the future transmit path.

## Test plan
- Valid unicast frame to port 5005 with an 18-byte payload 0x00..0x11 → 18 `data_valid` beats, `data_chan`=0, `data_last` on 0x11, `drop_count`=0.
- Same frame sent to port 5006 with dest MAC broadcast → `data_chan`=1. With `ACCEPT_BCAST`=0 → no output, `drop_count`=1.
- IHL=6 (4 option bytes) with a correct checksum → payload delivered. The same frame with one checksum bit flipped → dropped, `drop_count` +1.
- `udp_len`=12 in a 60-byte padded frame → exactly 4 beats, with padding and FCS ignored. `udp_len`=8 → no beats, no drop.
- `frame_end` after 5 of 18 payload bytes → 5 beats, then a `data_abort` pulse, no `data_last`. The next frame parses normally.
- Unknown port 1234 → dropped, `drop_count` +1. With `CNT_W`=2, 5 such frames → `drop_count`=3 (saturated).
